// File: rtl/hex_digit_driver.sv
// hex_digit_driver
//   Drives one active-low seven-segment digit from a 4-bit nibble that
//   software leaves in a HEX output port. After reset the digit runs a lamp
//   test (all segments lit) for LAMP_CYCLES cycles. From then on it shows the
//   decoded nibble, lights the decimal point for FLASH_CYCLES cycles after each
//   value change, and can be blanked or blinked.
//
//   state | meaning
//   ------+-----------------------------------------------
//   LAMP  | lamp test, all segments lit, inputs ignored
//   RUN   | normal display, stays here until reset
//
// Ports
//   clk        in   1  system clock
//   reset      in   1  synchronous reset, active-high
//   value_in   in   4  nibble to display (level input, no strobe)
//   blank      in   1  1 = digit dark (ignored during lamp test)
//   blink_en   in   1  1 = alternate shown/dark every BLINK_HALF cycles
//   hex_out    out  8  active-low {dp,g,f,e,d,c,b,a}, registered
//   lamp_busy  out  1  1 while the lamp test runs
module hex_digit_driver #(
    parameter int LAMP_CYCLES  = 50_000_000,
    parameter int BLINK_HALF   = 25_000_000,
    parameter int FLASH_CYCLES = 5_000_000,
    parameter int CNT_W        = 26
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] value_in,
    input  logic       blank,
    input  logic       blink_en,
    output logic [7:0] hex_out,
    output logic       lamp_busy
);

    localparam logic [0:0] ST_LAMP = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Terminal counts: the cycle that shows a count of zero is the last one.
    localparam logic [CNT_W-1:0] LAMP_LAST  = CNT_W'(LAMP_CYCLES - 1);
    localparam logic [CNT_W-1:0] FLASH_LAST = CNT_W'(FLASH_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_HALF - 1);

    logic [0:0]       r_state;
    logic [CNT_W-1:0] r_lamp_cnt;
    logic [CNT_W-1:0] r_flash_cnt;
    logic [CNT_W-1:0] r_blink_cnt;
    logic             r_blink_off;
    logic [3:0]       r_prev_val;
    logic [7:0]       r_hex_out;
    logic             r_lamp_busy;

    logic             w_change;
    logic             w_flash_active;
    logic             w_dark;
    logic [7:0]       w_run_hex;

    function automatic logic [6:0] f_decode(input logic [3:0] v);
        logic [6:0] seg;
        case (v)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    // The change cycle itself already shows the DP, so the count is loaded
    // with FLASH_CYCLES-1 to give exactly FLASH_CYCLES lit cycles.
    assign w_change       = (value_in != r_prev_val);
    assign w_flash_active = w_change || (r_flash_cnt != '0);

    // Gating the phase with blink_en lets the digit reappear on the very
    // cycle blink_en drops, even if the stored phase is still OFF.
    assign w_dark    = blank || (blink_en && r_blink_off);
    assign w_run_hex = w_dark ? 8'hFF : {~w_flash_active, f_decode(value_in)};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_LAMP;
            r_lamp_cnt  <= LAMP_LAST;
            r_flash_cnt <= '0;
            r_blink_cnt <= '0;
            r_blink_off <= 1'b0;
            r_prev_val  <= value_in;
            r_hex_out   <= 8'hFF;
            r_lamp_busy <= 1'b0;
        end else begin
            r_prev_val <= value_in;
            case (r_state)
                ST_LAMP: begin
                    r_hex_out   <= 8'h00;
                    r_lamp_busy <= 1'b1;
                    if (r_lamp_cnt == '0) begin
                        r_state <= ST_RUN;
                    end else begin
                        r_lamp_cnt <= r_lamp_cnt - 1'b1;
                    end
                end
                default: begin
                    r_hex_out   <= w_run_hex;
                    r_lamp_busy <= 1'b0;

                    if (w_change) begin
                        r_flash_cnt <= FLASH_LAST;
                    end else if (r_flash_cnt != '0) begin
                        r_flash_cnt <= r_flash_cnt - 1'b1;
                    end

                    if (!blink_en) begin
                        r_blink_cnt <= '0;
                        r_blink_off <= 1'b0;
                    end else if (r_blink_cnt == BLINK_LAST) begin
                        r_blink_cnt <= '0;
                        r_blink_off <= ~r_blink_off;
                    end else begin
                        r_blink_cnt <= r_blink_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    assign hex_out   = r_hex_out;
    assign lamp_busy = r_lamp_busy;

endmodule

// File: tb/tb_hex_digit_driver.sv
module tb_hex_digit_driver;

    localparam int LAMP  = 4;
    localparam int BLINK = 3;
    localparam int FLASH = 2;

    logic       clk;
    logic       reset;
    logic [3:0] value_in;
    logic       blank;
    logic       blink_en;
    logic [7:0] hex_out;
    logic       lamp_busy;

    hex_digit_driver #(
        .LAMP_CYCLES (LAMP),
        .BLINK_HALF  (BLINK),
        .FLASH_CYCLES(FLASH),
        .CNT_W       (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .value_in (value_in),
        .blank    (blank),
        .blink_en (blink_en),
        .hex_out  (hex_out),
        .lamp_busy(lamp_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] val;
        logic       blank;
        logic       blink;
        logic [7:0] hex;
        logic       busy;
    } vec_t;

    vec_t vecs[$];

    int errors = 0;
    int checks = 0;

    // Reference model: counts edges rather than mirroring any counter logic.
    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    int         m_edge       = 0;
    int         m_lamp_seen  = 0;
    int         m_last_chg   = -1000;
    int         m_blink_age  = 0;
    logic [3:0] m_prev       = 4'h0;
    logic [7:0] m_hex;
    logic       m_busy;

    task automatic model_edge();
        bit flash;
        bit off;
        m_edge++;
        if (reset) begin
            m_hex       = 8'hFF;
            m_busy      = 1'b0;
            m_lamp_seen = 0;
            m_last_chg  = -1000;
            m_blink_age = 0;
        end else if (m_lamp_seen < LAMP) begin
            m_hex       = 8'h00;
            m_busy      = 1'b1;
            m_lamp_seen++;
            m_blink_age = 0;
        end else begin
            if (value_in != m_prev) m_last_chg = m_edge;
            flash  = (m_edge - m_last_chg) < FLASH;
            off    = blink_en && (((m_blink_age / BLINK) % 2) == 1);
            m_hex  = (blank || off) ? 8'hFF : {~flash, seg_tab[value_in]};
            m_busy = 1'b0;
            m_blink_age = blink_en ? m_blink_age + 1 : 0;
        end
        m_prev = value_in;
    endtask

    task automatic check8(input string name, input int idx, input logic [7:0] got,
                          input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %02h want %02h", name, idx, got, exp);
        end
    endtask

    task automatic check1(input string name, input int idx, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0b want %0b", name, idx, got, exp);
        end
    endtask

    task automatic apply(input logic r, input logic [3:0] v, input logic b, input logic bl);
        reset    = r;
        value_in = v;
        blank    = b;
        blink_en = bl;
    endtask

    // One clock edge: the model sees the same inputs as the DUT, outputs are
    // compared 1 time unit after the edge.
    task automatic tick_and_check(input string name, input int idx);
        @(posedge clk);
        model_edge();
        #1;
        check8({name, "_hex_model"}, idx, hex_out, m_hex);
        check1({name, "_busy_model"}, idx, lamp_busy, m_busy);
    endtask

    function automatic vec_t mk(input logic r, input logic [3:0] v, input logic b,
                                input logic bl, input logic [7:0] h, input logic bu);
        vec_t x;
        x.rst = r; x.val = v; x.blank = b; x.blink = bl; x.hex = h; x.busy = bu;
        return x;
    endfunction

    initial begin
        apply(1'b1, 4'h0, 1'b0, 1'b0);

        // Reset, then lamp test, then first decoded value.
        repeat (3) vecs.push_back(mk(1, 4'h0, 0, 0, 8'hFF, 0));
        repeat (4) vecs.push_back(mk(0, 4'h0, 0, 0, 8'h00, 1));
        vecs.push_back(mk(0, 4'h0, 0, 0, 8'hC0, 0));
        // 0 -> 5 flashes DP for two cycles; holding 5 does not.
        vecs.push_back(mk(0, 4'h5, 0, 0, 8'h12, 0));
        vecs.push_back(mk(0, 4'h5, 0, 0, 8'h12, 0));
        vecs.push_back(mk(0, 4'h5, 0, 0, 8'h92, 0));
        vecs.push_back(mk(0, 4'h5, 0, 0, 8'h92, 0));
        // Settle on 1, then 1 -> 2 -> 3 retriggers the flash.
        vecs.push_back(mk(0, 4'h1, 0, 0, 8'h79, 0));
        vecs.push_back(mk(0, 4'h1, 0, 0, 8'h79, 0));
        vecs.push_back(mk(0, 4'h1, 0, 0, 8'hF9, 0));
        vecs.push_back(mk(0, 4'h2, 0, 0, 8'h24, 0));
        vecs.push_back(mk(0, 4'h3, 0, 0, 8'h30, 0));
        vecs.push_back(mk(0, 4'h3, 0, 0, 8'h30, 0));
        vecs.push_back(mk(0, 4'h3, 0, 0, 8'hB0, 0));
        // Settle on 8, then blink: 3 on, 3 off, 3 on, 2 off, drop -> shown.
        vecs.push_back(mk(0, 4'h8, 0, 0, 8'h00, 0));
        vecs.push_back(mk(0, 4'h8, 0, 0, 8'h00, 0));
        vecs.push_back(mk(0, 4'h8, 0, 0, 8'h80, 0));
        repeat (3) vecs.push_back(mk(0, 4'h8, 0, 1, 8'h80, 0));
        repeat (3) vecs.push_back(mk(0, 4'h8, 0, 1, 8'hFF, 0));
        repeat (3) vecs.push_back(mk(0, 4'h8, 0, 1, 8'h80, 0));
        repeat (2) vecs.push_back(mk(0, 4'h8, 0, 1, 8'hFF, 0));
        vecs.push_back(mk(0, 4'h8, 0, 0, 8'h80, 0));
        // Blank overrides blink and a pending flash; the flash runs out unseen.
        repeat (4) vecs.push_back(mk(0, 4'h3, 1, 1, 8'hFF, 0));
        vecs.push_back(mk(0, 4'h3, 0, 0, 8'hB0, 0));
        // Reset during blink restarts the lamp test; blank ignored in lamp.
        vecs.push_back(mk(0, 4'h3, 0, 1, 8'hB0, 0));
        repeat (2) vecs.push_back(mk(1, 4'h3, 0, 1, 8'hFF, 0));
        repeat (4) vecs.push_back(mk(0, 4'h3, 1, 1, 8'h00, 1));
        vecs.push_back(mk(0, 4'h3, 0, 0, 8'hB0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].rst, vecs[i].val, vecs[i].blank, vecs[i].blink);
            tick_and_check("vec", i);
            check8("vec_hex", i, hex_out, vecs[i].hex);
            check1("vec_busy", i, lamp_busy, vecs[i].busy);
        end

        // Random soak against the model.
        for (int i = 0; i < 3000; i++) begin
            logic       r;
            logic [3:0] v;
            logic       b;
            logic       bl;
            r  = ($urandom_range(0, 199) == 0);
            v  = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : value_in;
            b  = ($urandom_range(0, 7) == 0);
            bl = ($urandom_range(0, 19) == 0) ? ~blink_en : blink_en;
            apply(r, v, b, bl);
            tick_and_check("rand", i);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
